npu_instr_sequencer: RTL

Instruction-memory controller sitting between the host/testbench and the NPU instruction port. The host loads a program while the block is idle. On start, the block serves the NPU's get_instr/get_instr_addr fetches with 1-cycle latency. It counts END_CHAIN completions to run the program a configured number of times, then waits out a fixed pipeline drain and signals done.

---
 rtl/npu_instr_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/npu_instr_sequencer.sv
// Instruction-memory sequencer: host loads a program while idle, then NPU fetches are served
// with 1-cycle latency, END_CHAIN returns count down passes, and a fixed drain precedes done.
// Optional performance counters are enabled by defining NPU_SEQ_PERF_CNT_EN.
module npu_instr_sequencer #(
    parameter int INSTR_WIDTH      = 47,
    parameter int INSTR_MEM_AWIDTH = 9,
    parameter int OPCODE_WIDTH     = 4,
    parameter int END_CHAIN_OP     = 12,
    parameter int DRAIN_CYCLES     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        host_we,
    input  logic [INSTR_MEM_AWIDTH-1:0] host_addr,
    input  logic [INSTR_WIDTH-1:0]      host_wdata,
    output logic                        host_busy,
    input  logic                        start,
    input  logic [INSTR_MEM_AWIDTH-1:0] last_addr,
    input  logic [7:0]                  loop_count,
    input  logic                        get_instr,
    input  logic [INSTR_MEM_AWIDTH-1:0] get_instr_addr,
    output logic [INSTR_WIDTH-1:0]      instruction,
    output logic                        instr_valid,
    output logic                        done,
    output logic                        err_oob
`ifdef NPU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_run_cycles,
    output logic [31:0]                 perf_fetches
`endif
);

    localparam int DEPTH = 1 << INSTR_MEM_AWIDTH;
    localparam logic [INSTR_WIDTH-1:0] END_WORD =
        {OPCODE_WIDTH'(END_CHAIN_OP), {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [INSTR_MEM_AWIDTH-1:0] last_q, last_d;
    logic [7:0]                  remaining_q, remaining_d;
    logic [7:0]                  drain_q, drain_d;
    logic                        err_q, err_d;
    logic                        done_q, done_d;
    logic                        vld_q, have_q, oob_q;
    logic [INSTR_WIDTH-1:0]      rd_q;
    logic [INSTR_WIDTH-1:0]      mem [DEPTH];

    logic start_acc, host_wr, fetch_acc, end_hit, last_pass;

    assign start_acc = (state_q == S_IDLE) && start;
    assign host_wr   = (state_q == S_IDLE) && host_we;

    // Out-of-range fetches read the array anyway but are replaced by a synthetic END_CHAIN;
    // have_q keeps the output at zero until the first fetch after reset.
    assign instruction = !have_q ? '0 : (oob_q ? END_WORD : rd_q);
    assign instr_valid = vld_q;
    assign end_hit     = vld_q && (instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH]
                                   == OPCODE_WIDTH'(END_CHAIN_OP));
    assign last_pass   = end_hit && (remaining_q == 8'd1);

    assign host_busy = (state_q != S_IDLE);
    assign done      = done_q;
    assign err_oob   = err_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        drain_d     = drain_q;
        err_d       = err_q;
        done_d      = 1'b0;
        fetch_acc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d      = last_addr;
                    remaining_d = (loop_count == 8'd0) ? 8'd1 : loop_count;
                    err_d       = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                // The cycle that returns the final END_CHAIN already belongs to the shutdown.
                fetch_acc = get_instr && !last_pass;
                if (fetch_acc && (get_instr_addr > last_q)) err_d = 1'b1;
                if (end_hit) remaining_d = remaining_q - 8'd1;
                if (last_pass) begin
                    state_d = S_DRAIN;
                    drain_d = 8'd0;
                end
            end
            S_DRAIN: begin
                if (drain_q == 8'(DRAIN_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    drain_d = 8'd0;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= '0;
            remaining_q <= '0;
            drain_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= 1'b0;
            have_q      <= 1'b0;
            oob_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            err_q       <= err_d;
            done_q      <= done_d;
            vld_q       <= fetch_acc;
            if (fetch_acc) begin
                have_q <= 1'b1;
                oob_q  <= (get_instr_addr > last_q);
            end
        end
    end

    // Single-port array: writes only in IDLE, reads only in RUN, so they never collide.
    always_ff @(posedge clk) begin
        if (host_wr) mem[host_addr] <= host_wdata;
        if (fetch_acc) rd_q <= mem[get_instr_addr];
    end

`ifdef NPU_SEQ_PERF_CNT_EN
    logic [31:0] perf_run_q, perf_fetch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_run_q   <= '0;
            perf_fetch_q <= '0;
        end else if (start_acc) begin
            perf_run_q   <= '0;
            perf_fetch_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (perf_run_q != '1)) perf_run_q <= perf_run_q + 32'd1;
            if (fetch_acc && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'd1;
        end
    end

    assign perf_run_cycles = perf_run_q;
    assign perf_fetches    = perf_fetch_q;
`endif

endmodule
